// File: rtl/snoop_bus_arbiter_if.sv
// snoop_bus_arbiter_if: request, snoop-response and memory signals of the shared snooping bus.
interface snoop_bus_arbiter_if #(
    parameter int NUM_CPUS = 4,
    parameter int CPU_ID_W = 2,
    parameter int ADDR_W   = 16
);
    logic [NUM_CPUS-1:0]        req;
    logic [2*NUM_CPUS-1:0]      req_op;
    logic [ADDR_W*NUM_CPUS-1:0] req_addr;
    logic [NUM_CPUS-1:0]        grant;
    logic [NUM_CPUS-1:0]        done;
    logic [1:0]                 bus_acao;
    logic [ADDR_W-1:0]          bus_addr;
    logic [CPU_ID_W-1:0]        bus_src;
    logic [NUM_CPUS-1:0]        snoop_wb;
    logic [NUM_CPUS-1:0]        snoop_abort;
    logic                       mem_req;
    logic                       mem_we;
    logic                       mem_ready;
    logic                       busy;
    logic                       proto_err;
    modport master (
        input  req, req_op, req_addr, snoop_wb, snoop_abort, mem_ready,
        output grant, done, bus_acao, bus_addr, bus_src, mem_req, mem_we, busy, proto_err
    );
    modport slave (
        output req, req_op, req_addr, snoop_wb, snoop_abort, mem_ready,
        input  grant, done, bus_acao, bus_addr, bus_src, mem_req, mem_we, busy, proto_err
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin owner selection, one-cycle coherence broadcast, writeback/retry and memory access.
module snoop_bus_arbiter #(
    parameter int NUM_CPUS = 4,
    parameter int CPU_ID_W = 2,
    parameter int ADDR_W   = 16
) (
    input logic clock,
    input logic reset,
    snoop_bus_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, BCAST, SNOOP, WB, MEM, DONE} state_t;
    state_t state;
    logic [1:0] op;
    logic [CPU_ID_W-1:0] rr_ptr, pick;
    logic pick_ok;
    logic [NUM_CPUS-1:0] elig, hit, bad;
    for (genvar i = 0; i < NUM_CPUS; i++) begin : g_elig
        assign elig[i] = bus.req[i] && bus.req_op[2*i +: 2] != 2'b11;
    end
    // The owner's own snoop bits describe its own cache and never force a writeback.
    assign hit = bus.snoop_abort & ~bus.grant;
    assign bad = (bus.snoop_wb ^ bus.snoop_abort) & ~bus.grant;
    // Walk downwards so the eligible requester closest to rr_ptr wins.
    always_comb begin
        pick_ok = 1'b0;
        pick    = '0;
        for (int k = NUM_CPUS - 1; k >= 0; k--) begin
            if (elig[(int'(rr_ptr) + k) % NUM_CPUS]) begin
                pick_ok = 1'b1;
                pick    = CPU_ID_W'((int'(rr_ptr) + k) % NUM_CPUS);
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            op            <= 2'b11;
            rr_ptr        <= '0;
            bus.grant     <= '0;
            bus.done      <= '0;
            bus.bus_acao  <= 2'b11;
            bus.bus_addr  <= '0;
            bus.bus_src   <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_ok) begin
                    state        <= BCAST;
                    op           <= bus.req_op[2*pick +: 2];
                    bus.bus_acao <= bus.req_op[2*pick +: 2];
                    bus.bus_addr <= bus.req_addr[ADDR_W*pick +: ADDR_W];
                    bus.bus_src  <= pick;
                    bus.grant    <= NUM_CPUS'(1) << pick;
                    bus.busy     <= 1'b1;
                end
                BCAST: begin
                    state        <= SNOOP;
                    bus.bus_acao <= 2'b11;
                end
                SNOOP: begin
                    if (|bad) bus.proto_err <= 1'b1;
                    if (|hit) begin
                        state       <= WB;
                        bus.mem_req <= 1'b1;
                        bus.mem_we  <= 1'b1;
                    end else if (op == 2'b01) begin
                        state    <= DONE;
                        bus.done <= bus.grant;
                    end else begin
                        state       <= MEM;
                        bus.mem_req <= 1'b1;
                    end
                end
                // Dirty line is now in memory: replay the same action so snoopers re-evaluate.
                WB: if (bus.mem_ready) begin
                    state        <= BCAST;
                    bus.mem_req  <= 1'b0;
                    bus.mem_we   <= 1'b0;
                    bus.bus_acao <= op;
                end
                MEM: if (bus.mem_ready) begin
                    state       <= DONE;
                    bus.mem_req <= 1'b0;
                    bus.done    <= bus.grant;
                end
                DONE: begin
                    state     <= IDLE;
                    bus.done  <= '0;
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                    rr_ptr    <= bus.bus_src == CPU_ID_W'(NUM_CPUS - 1) ? '0 : bus.bus_src + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: directed scenarios plus randomized traffic, checked every cycle against a transaction-level model.
module tb_snoop_bus_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    snoop_bus_arbiter_if #(.NUM_CPUS(N), .CPU_ID_W(2), .ADDR_W(AW)) bus();
    snoop_bus_arbiter #(.NUM_CPUS(N), .CPU_ID_W(2), .ADDR_W(AW)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );
    int checks = 0;
    int errors = 0;
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    // Model: phase of the current transaction (0 idle, 1 broadcast, 2 snoop, 3 writeback, 4 fetch, 5 done).
    int m_phase = 0, m_owner = -1, m_rr = 0;
    logic [1:0] m_op;
    logic [AW-1:0] m_addr;
    logic m_err = 1'b0;
    bit model_on = 1'b0;
    initial forever begin
        @(posedge clock);
        if (reset) begin
            m_phase = 0; m_owner = -1; m_rr = 0; m_err = 1'b0; model_on = 1'b1;
        end else if (model_on) begin
            case (m_phase)
                0: for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_rr + k) % N;
                    if (m_owner < 0 && bus.req[i] && bus.req_op[2*i +: 2] != 2'b11) begin
                        m_owner = i; m_op = bus.req_op[2*i +: 2]; m_addr = bus.req_addr[AW*i +: AW]; m_phase = 1;
                    end
                end
                1: m_phase = 2;
                2: begin
                    logic [N-1:0] others;
                    others = ~(N'(1) << m_owner);
                    if (((bus.snoop_wb ^ bus.snoop_abort) & others) != 0) m_err = 1'b1;
                    m_phase = (bus.snoop_abort & others) != 0 ? 3 : m_op == 2'b01 ? 5 : 4;
                end
                3: if (bus.mem_ready) m_phase = 1;
                4: if (bus.mem_ready) m_phase = 5;
                default: begin m_rr = (m_owner + 1) % N; m_owner = -1; m_phase = 0; end
            endcase
        end
    end
    logic [N-1:0] e_grant;
    initial forever begin
        @(negedge clock);
        if (model_on) begin
            e_grant = '0;
            if (m_owner >= 0) e_grant[m_owner] = 1'b1;
            check("grant", bus.grant, e_grant);
            check("done", bus.done, m_phase == 5 ? e_grant : '0);
            check("bus_acao", bus.bus_acao, m_phase == 1 ? m_op : 2'b11);
            check("mem_req", bus.mem_req, m_phase == 3 || m_phase == 4);
            check("mem_we", bus.mem_we, m_phase == 3);
            check("busy", bus.busy, m_phase != 0);
            check("proto_err", bus.proto_err, m_err);
            if (m_phase != 0) check("bus_src", bus.bus_src, m_owner);
            if (m_phase == 1 || m_phase == 3) check("bus_addr", bus.bus_addr, m_addr);
        end
    end
    // Memory responder: 0 = ready on the 2nd cycle of each request, 1 = random, 2 = never.
    int rmode = 0, mcnt = 0;
    initial begin
        bus.mem_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            mcnt = bus.mem_req ? mcnt + 1 : 0;
            bus.mem_ready = rmode == 0 ? mcnt == 2 : rmode == 1 ? $urandom % 3 == 0 : 1'b0;
        end
    end
    int obs_acao, obs_addr, obs_we, obs_mem, obs_busy, obs_grant, obs_done_at;
    int order[$];
    task automatic observe(input int n, input logic [1:0] wop, input logic [AW-1:0] waddr);
        obs_acao = 0; obs_addr = 0; obs_we = 0; obs_mem = 0; obs_busy = 0; obs_grant = 0; obs_done_at = -1;
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            if (bus.bus_acao == wop) begin
                obs_acao++;
                if (bus.bus_addr == waddr) obs_addr++;
            end
            if (bus.mem_we) begin obs_we++; bus.snoop_abort = '0; bus.snoop_wb = '0; end
            if (bus.mem_req && !bus.mem_we) obs_mem++;
            if (bus.busy) obs_busy++;
            if (bus.grant != 0) obs_grant++;
            if (bus.done != 0 && obs_done_at < 0) obs_done_at = c;
            for (int i = 0; i < N; i++) if (bus.done[i]) begin order.push_back(i); bus.req[i] = 1'b0; end
        end
    endtask
    task automatic set_cpu(input int i, input logic [1:0] op, input logic [AW-1:0] addr);
        bus.req[i] = 1'b1;
        bus.req_op[2*i +: 2] = op;
        bus.req_addr[AW*i +: AW] = addr;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0; bus.snoop_abort = '0; bus.snoop_wb = '0;
        @(posedge clock);
        #1 reset = 1'b0;
        order.delete();
    endtask
    initial begin
        bus.req = '0; bus.req_op = '1; bus.req_addr = '0; bus.snoop_wb = '0; bus.snoop_abort = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_grant", bus.grant, 0);
        check("rst_acao", bus.bus_acao, 2'b11);
        check("rst_busy", bus.busy, 0);
        @(posedge clock); #1;
        set_cpu(0, 2'b01, 16'h0040);
        observe(8, 2'b01, 16'h0040);
        check("t1_acao_cycles", obs_acao, 1);
        check("t1_addr", obs_addr, 1);
        check("t1_done_latency", obs_done_at, 3);
        check("t1_model_rr", m_rr, 1);
        do_reset();
        for (int i = 0; i < N; i++) set_cpu(i, 2'b00, AW'(16'h0100 + i));
        observe(40, 2'b00, 16'h0100);
        check("t2_count", order.size(), 4);
        for (int k = 0; k < 4; k++) check("t2_order", order.size() > k ? order[k] : -1, k);
        check("t2_acao_cycles", obs_acao, 4);
        do_reset();
        set_cpu(1, 2'b10, 16'h1234);
        bus.snoop_abort = 4'b0100; bus.snoop_wb = 4'b0100;
        observe(15, 2'b10, 16'h1234);
        check("t3_rebroadcast", obs_addr, 2);
        check("t3_wb_cycles", obs_we, 2);
        check("t3_mem_cycles", obs_mem, 2);
        check("t3_done_latency", obs_done_at, 9);
        check("t3_proto_err", bus.proto_err, 0);
        do_reset();
        set_cpu(1, 2'b00, 16'h0abc);
        bus.snoop_abort = 4'b0010; bus.snoop_wb = 4'b1010;
        observe(10, 2'b00, 16'h0abc);
        check("t4_no_wb", obs_we, 0);
        check("t4_done_latency", obs_done_at, 5);
        check("t4_proto_err", bus.proto_err, 1);
        bus.snoop_abort = '0; bus.snoop_wb = '0;
        set_cpu(2, 2'b01, 16'h0abd);
        observe(8, 2'b01, 16'h0abd);
        check("t4_sticky", bus.proto_err, 1);
        do_reset();
        @(negedge clock);
        check("t4_cleared", bus.proto_err, 0);
        set_cpu(0, 2'b00, 16'h0011);
        observe(10, 2'b00, 16'h0011);
        set_cpu(0, 2'b00, 16'h0022);
        set_cpu(3, 2'b00, 16'h0033);
        rmode = 2;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 10 && seen == 0; c++) begin
                @(negedge clock);
                if (bus.mem_req) seen = 1;
            end
            check("t5_reached_mem", seen, 1);
        end
        check("t5_owner", bus.grant, 4'b1000);
        reset = 1'b1;
        @(negedge clock);
        check("t5_grant", bus.grant, 0);
        check("t5_done", bus.done, 0);
        check("t5_acao", bus.bus_acao, 2'b11);
        check("t5_addr", bus.bus_addr, 0);
        check("t5_src", bus.bus_src, 0);
        check("t5_memreq", {bus.mem_req, bus.mem_we, bus.busy, bus.proto_err}, 0);
        reset = 1'b0;
        rmode = 0;
        order.delete();
        observe(12, 2'b00, 16'h0022);
        check("t5_rearb", order.size() > 0 ? order[0] : -1, 0);
        do_reset();
        set_cpu(2, 2'b11, 16'h0055);
        observe(10, 2'b11, 16'h0055);
        check("t6_acao_null", obs_acao, 10);
        check("t6_busy", obs_busy, 0);
        check("t6_grant", obs_grant, 0);
        rmode = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            reset = $urandom % 400 == 0;
            for (int i = 0; i < N; i++) begin
                if (bus.done[i] && $urandom % 4 != 0) bus.req[i] = 1'b0;
                else if ($urandom % 8 == 0) bus.req[i] = ~bus.req[i];
                if ($urandom % 6 == 0) bus.req_op[2*i +: 2] = 2'($urandom);
                if ($urandom % 5 == 0) bus.req_addr[AW*i +: AW] = AW'($urandom);
            end
            bus.snoop_abort = $urandom % 4 == 0 ? 4'($urandom) : '0;
            bus.snoop_wb = $urandom % 8 == 0 ? 4'($urandom) : bus.snoop_abort;
        end
        reset = 1'b0;
        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
